// File: rtl/ext_int_portd.sv
// Port D external interrupt block: INT0/INT1 sense control and PCINT2 pin-change
// flags with synchronised pin sampling and an I/O plus data-space register file.
module ext_int_portd #(
  parameter logic [5:0] PCIFR_ADDR = 6'h1B,
  parameter logic [5:0] EIFR_ADDR  = 6'h1C,
  parameter logic [5:0] EIMSK_ADDR = 6'h1D,
  parameter logic [7:0] PCICR_ADR  = 8'h68,
  parameter logic [7:0] EICRA_ADR  = 8'h69,
  parameter logic [7:0] PCMSK2_ADR = 8'h6D
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] pinD_i,
  output logic       INT0_EN,
  output logic       INT1_EN,
  output logic       PCIE2,
  output logic [7:0] PCINT,
  output logic       int0_irq,
  output logic       int1_irq,
  output logic       pcint2_irq,
  input  logic       int0_ack,
  input  logic       int1_ack,
  input  logic       pcint2_ack
);

  typedef enum logic [1:0] {
    ISC_LOW  = 2'b00,
    ISC_ANY  = 2'b01,
    ISC_FALL = 2'b10,
    ISC_RISE = 2'b11
  } isc_e;

  logic [7:0] r_s1, r_s2, r_s3;
  logic [1:0] r_arm;
  logic [3:0] r_eicra;
  logic [1:0] r_eimsk;
  logic [1:0] r_intf;
  logic       r_pcie2;
  logic       r_pcif;
  logic [7:0] r_pcmsk2;

  logic       w_eicra_we, w_eimsk_we, w_eifr_we, w_pcicr_we, w_pcifr_we, w_pcmsk2_we;
  logic       w_armed;
  logic [7:0] w_chg;
  logic [1:0] w_level;
  logic [1:0] w_int_hit;
  logic [1:0] w_intf_set, w_intf_clr;
  logic       w_pcif_set, w_pcif_clr;

  function automatic logic edge_hit(input logic [1:0] isc, input logic cur, input logic prev);
    case (isc_e'(isc))
      ISC_ANY:  edge_hit = cur ^ prev;
      ISC_FALL: edge_hit = prev & ~cur;
      ISC_RISE: edge_hit = cur & ~prev;
      default:  edge_hit = 1'b0;
    endcase
  endfunction

  assign w_eimsk_we  = iowe  && (IO_Addr == EIMSK_ADDR);
  assign w_eifr_we   = iowe  && (IO_Addr == EIFR_ADDR);
  assign w_pcifr_we  = iowe  && (IO_Addr == PCIFR_ADDR);
  assign w_eicra_we  = ramwe && (ramadr == EICRA_ADR);
  assign w_pcicr_we  = ramwe && (ramadr == PCICR_ADR);
  assign w_pcmsk2_we = ramwe && (ramadr == PCMSK2_ADR);

  assign w_armed = (r_arm == 2'd3);
  assign w_chg   = r_s2 ^ r_s3;
  assign w_level = {r_eicra[3:2] == ISC_LOW, r_eicra[1:0] == ISC_LOW};

  assign w_int_hit[0] = edge_hit(r_eicra[1:0], r_s2[2], r_s3[2]);
  assign w_int_hit[1] = edge_hit(r_eicra[3:2], r_s2[3], r_s3[3]);

  // A write to EICRA can change the edge sense mid-cycle, so no INTF may set then.
  assign w_intf_set = w_int_hit & {2{w_armed & ~w_eicra_we}};
  assign w_intf_clr = (w_eifr_we ? dbus_in[1:0] : 2'b00) | {int1_ack, int0_ack};
  assign w_pcif_set = w_armed & (|(w_chg & r_pcmsk2));
  assign w_pcif_clr = (w_pcifr_we & dbus_in[2]) | pcint2_ack;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which the synchroniser chain relies on.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_s1  <= 8'hFF;
      r_s2  <= 8'hFF;
      r_s3  <= 8'hFF;
      r_arm <= 2'd0;
    end else begin
      r_s1 <= pinD_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!w_armed) r_arm <= r_arm + 2'd1;
    end
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_eicra  <= 4'h0;
      r_eimsk  <= 2'b00;
      r_intf   <= 2'b00;
      r_pcie2  <= 1'b0;
      r_pcif   <= 1'b0;
      r_pcmsk2 <= 8'h00;
    end else begin
      if (w_eicra_we)  r_eicra  <= dbus_in[3:0];
      if (w_eimsk_we)  r_eimsk  <= dbus_in[1:0];
      if (w_pcicr_we)  r_pcie2  <= dbus_in[2];
      if (w_pcmsk2_we) r_pcmsk2 <= dbus_in;
      // Hardware set wins over a simultaneous clear; level mode holds the flag low.
      r_intf <= ((r_intf & ~w_intf_clr) | w_intf_set) & ~w_level;
      r_pcif <= (r_pcif & ~w_pcif_clr) | w_pcif_set;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (!ireset) begin
      if (iore) begin
        case (IO_Addr)
          PCIFR_ADDR: begin dbus_out = {5'b0, r_pcif, 2'b0}; out_en = 1'b1; end
          EIFR_ADDR:  begin dbus_out = {6'b0, r_intf};       out_en = 1'b1; end
          EIMSK_ADDR: begin dbus_out = {6'b0, r_eimsk};      out_en = 1'b1; end
          default: ;
        endcase
      end
      if (ramre && !out_en) begin
        case (ramadr)
          PCICR_ADR:  begin dbus_out = {5'b0, r_pcie2, 2'b0}; out_en = 1'b1; end
          EICRA_ADR:  begin dbus_out = {4'b0, r_eicra};       out_en = 1'b1; end
          PCMSK2_ADR: begin dbus_out = r_pcmsk2;              out_en = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  assign INT0_EN    = r_eimsk[0];
  assign INT1_EN    = r_eimsk[1];
  assign PCIE2      = r_pcie2;
  assign PCINT      = r_pcmsk2;
  assign int0_irq   = r_eimsk[0] & (w_level[0] ? ~r_s2[2] : r_intf[0]);
  assign int1_irq   = r_eimsk[1] & (w_level[1] ? ~r_s2[3] : r_intf[1]);
  assign pcint2_irq = r_pcie2 & r_pcif;

endmodule

// File: tb/tb_ext_int_portd.sv
// Directed self-checking bench for ext_int_portd: register access, INT0/INT1
// sense modes, PCINT2 masking, set-over-clear priority and asynchronous reset.
module tb_ext_int_portd;

  logic       cp2, ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] ramadr;
  logic       ramre, ramwe;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en;
  logic [7:0] pinD_i;
  logic       INT0_EN, INT1_EN, PCIE2;
  logic [7:0] PCINT;
  logic       int0_irq, int1_irq, pcint2_irq;
  logic       int0_ack, int1_ack, pcint2_ack;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd;
  logic       en;

  ext_int_portd dut (
    .cp2(cp2), .ireset(ireset),
    .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
    .pinD_i(pinD_i),
    .INT0_EN(INT0_EN), .INT1_EN(INT1_EN), .PCIE2(PCIE2), .PCINT(PCINT),
    .int0_irq(int0_irq), .int1_irq(int1_irq), .pcint2_irq(pcint2_irq),
    .int0_ack(int0_ack), .int1_ack(int1_ack), .pcint2_ack(pcint2_ack)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge cp2);
    IO_Addr = a; dbus_in = d; iowe = 1'b1;
    @(posedge cp2); #1;
    iowe = 1'b0;
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge cp2);
    ramadr = a; dbus_in = d; ramwe = 1'b1;
    @(posedge cp2); #1;
    ramwe = 1'b0;
  endtask

  task automatic io_rd(input logic [5:0] a, output logic [7:0] d, output logic e);
    IO_Addr = a; iore = 1'b1;
    #1;
    d = dbus_out; e = out_en;
    iore = 1'b0;
  endtask

  task automatic ram_rd(input logic [7:0] a, output logic [7:0] d, output logic e);
    ramadr = a; ramre = 1'b1;
    #1;
    d = dbus_out; e = out_en;
    ramre = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge cp2);
    #1;
  endtask

  task automatic set_pins(input logic [7:0] p);
    @(negedge cp2);
    pinD_i = p;
  endtask

  initial begin
    ireset = 1'b1; IO_Addr = '0; iore = 0; iowe = 0; ramadr = '0; ramre = 0; ramwe = 0;
    dbus_in = '0; pinD_i = 8'h00; int0_ack = 0; int1_ack = 0; pcint2_ack = 0;

    // Reset state
    cycles(3);
    io_rd(6'h1C, rd, en);
    check("rst_out_en", {7'b0, en}, 8'h00);
    check("rst_dbus", rd, 8'h00);
    check("rst_irqs", {5'b0, int0_irq, int1_irq, pcint2_irq}, 8'h00);
    check("rst_en", {5'b0, INT0_EN, INT1_EN, PCIE2}, 8'h00);
    check("rst_pcint", PCINT, 8'h00);

    // Synchroniser fill after release must not raise flags
    @(negedge cp2); ireset = 1'b0;
    cycles(10);
    io_rd(6'h1C, rd, en); check("arm_eifr", rd, 8'h00); check("arm_eifr_en", {7'b0, en}, 8'h01);
    io_rd(6'h1B, rd, en); check("arm_pcifr", rd, 8'h00);
    check("arm_irqs", {5'b0, int0_irq, int1_irq, pcint2_irq}, 8'h00);
    io_rd(6'h3F, rd, en); check("miss_out_en", {7'b0, en}, 8'h00); check("miss_dbus", rd, 8'h00);

    // INT0 falling edge: rising ignored, falling sets on 3rd edge
    ram_wr(8'h69, 8'h02);
    io_wr(6'h1D, 8'h01);
    check("int0_en", {7'b0, INT0_EN}, 8'h01);
    set_pins(8'h04); cycles(4);
    io_rd(6'h1C, rd, en); check("int0_rise_ignored", rd, 8'h00);
    set_pins(8'h00);
    cycles(2); check("int0_edge2", {7'b0, int0_irq}, 8'h00);
    cycles(1); check("int0_edge3", {7'b0, int0_irq}, 8'h01);
    io_rd(6'h1C, rd, en); check("int0_intf", rd, 8'h01);
    @(negedge cp2); int0_ack = 1'b1; @(posedge cp2); #1; int0_ack = 1'b0;
    check("int0_ack_irq", {7'b0, int0_irq}, 8'h00);
    io_rd(6'h1C, rd, en); check("int0_ack_intf", rd, 8'h00);

    // INT0 low level
    ram_wr(8'h69, 8'h00);
    check("lvl_irq_low", {7'b0, int0_irq}, 8'h01);
    io_rd(6'h1C, rd, en); check("lvl_eifr", rd, 8'h00);
    set_pins(8'h04);
    cycles(1); check("lvl_edge1", {7'b0, int0_irq}, 8'h01);
    cycles(1); check("lvl_edge2", {7'b0, int0_irq}, 8'h00);

    // INT1 any edge; set beats a simultaneous software clear
    ram_wr(8'h69, 8'h04);
    ram_rd(8'h69, rd, en); check("eicra_rd", rd, 8'h04);
    set_pins(8'h0C); cycles(4);
    io_rd(6'h1C, rd, en); check("int1_set", rd, 8'h02);
    set_pins(8'h04);
    @(posedge cp2); @(posedge cp2);
    io_wr(6'h1C, 8'h02);
    io_rd(6'h1C, rd, en); check("set_over_clr", rd, 8'h02);
    io_wr(6'h1C, 8'h02);
    io_rd(6'h1C, rd, en); check("sw_clr", rd, 8'h00);

    // EICRA write in the set cycle suppresses the flag
    set_pins(8'h0C);
    @(posedge cp2); @(posedge cp2);
    ram_wr(8'h69, 8'h04);
    io_rd(6'h1C, rd, en); check("eicra_suppress", rd, 8'h00);
    cycles(2);
    io_rd(6'h1C, rd, en); check("eicra_suppress_late", rd, 8'h00);

    // Unimplemented EIMSK bits
    io_wr(6'h1D, 8'hFF);
    io_rd(6'h1D, rd, en); check("eimsk_mask", rd, 8'h03);
    io_wr(6'h1D, 8'h01);

    // PCINT2: only masked pin sets the flag
    ram_wr(8'h6D, 8'h80);
    ram_wr(8'h68, 8'h04);
    check("pcint_port", PCINT, 8'h80);
    check("pcie2_port", {7'b0, PCIE2}, 8'h01);
    ram_rd(8'h68, rd, en); check("pcicr_rd", rd, 8'h04);
    set_pins(8'h4C); cycles(4);
    io_rd(6'h1B, rd, en); check("pd6_masked", rd, 8'h00);
    check("pd6_irq", {7'b0, pcint2_irq}, 8'h00);
    set_pins(8'hCC); cycles(4);
    io_rd(6'h1B, rd, en); check("pd7_set", rd, 8'h04);
    check("pd7_irq", {7'b0, pcint2_irq}, 8'h01);
    io_wr(6'h1B, 8'h04);
    io_rd(6'h1B, rd, en); check("pcifr_clr", rd, 8'h00);
    check("pcifr_clr_irq", {7'b0, pcint2_irq}, 8'h00);
    set_pins(8'h4C); cycles(4);
    check("pd7_fall_irq", {7'b0, pcint2_irq}, 8'h01);
    @(negedge cp2); pcint2_ack = 1'b1; @(posedge cp2); #1; pcint2_ack = 1'b0;
    check("pcint2_ack", {7'b0, pcint2_irq}, 8'h00);

    // Asynchronous reset aborts pending flags
    io_wr(6'h1D, 8'h03);
    set_pins(8'hC4); cycles(4);
    check("pre_rst_int1", {7'b0, int1_irq}, 8'h01);
    check("pre_rst_pcint2", {7'b0, pcint2_irq}, 8'h01);
    #1 ireset = 1'b1;
    #1;
    check("async_irqs", {5'b0, int0_irq, int1_irq, pcint2_irq}, 8'h00);
    check("async_en", {5'b0, INT0_EN, INT1_EN, PCIE2}, 8'h00);
    check("async_pcint", PCINT, 8'h00);
    io_rd(6'h1C, rd, en);
    check("async_out_en", {7'b0, en}, 8'h00);
    check("async_dbus", rd, 8'h00);
    @(negedge cp2); ireset = 1'b0;
    cycles(6);
    io_rd(6'h1C, rd, en); check("post_rst_eifr", rd, 8'h00);
    io_rd(6'h1B, rd, en); check("post_rst_pcifr", rd, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_int_portd.md
EXT_INT_PORTD -- requirements
Module: ext_int_portd

Interface
REQ-001 Parameters SHALL be: PCIFR_ADDR, 6'h1B, PCIFR I/O address; EIFR_ADDR, 6'h1C, EIFR I/O address; EIMSK_ADDR, 6'h1D, EIMSK I/O address; PCICR_ADR, 8'h68, PCICR data address; EICRA_ADR, 8'h69, EICRA data address; PCMSK2_ADR, 8'h6D, PCMSK2 data address.
REQ-002 Ports SHALL be the following, clock and reset first:
- cp2 in 1: clock.
- ireset in 1: reset.
- IO_Addr in 6: I/O address.
- iore in 1: I/O read strobe.
- iowe in 1: I/O write strobe.
- ramadr in 8: data address.
- ramre in 1: data read strobe.
- ramwe in 1: data write strobe.
- dbus_in in 8: write data.
- dbus_out out 8: read data.
- out_en out 1: read hit.
- pinD_i in 8: raw Port D pin levels.
- INT0_EN out 1: EIMSK[0].
- INT1_EN out 1: EIMSK[1].
- PCIE2 out 1: PCICR[2].
- PCINT out 8: PCMSK2.
- int0_irq out 1: INT0 request.
- int1_irq out 1: INT1 request.
- pcint2_irq out 1: PCINT2 request.
- int0_ack in 1: INT0 vector taken.
- int1_ack in 1: INT1 vector taken.
- pcint2_ack in 1: PCINT2 vector taken.
REQ-003 The block SHALL use one clock, cp2; ireset SHALL be asynchronous and active-high.

Function
REQ-004 Registers SHALL be:
- EICRA[3:0]: ISC11,ISC10,ISC01,ISC00.
- EIMSK[1:0].
- EIFR[1:0]: INTF1,INTF0.
- PCICR[2].
- PCIFR[2].
- PCMSK2[7:0].
Unimplemented bits SHALL read 0 and ignore writes.
REQ-005 Writes SHALL take effect at the cp2 edge where iowe (I/O address match) or ramwe (ramadr match) is high; EIFR and PCIFR writes SHALL clear each bit written 1 and leave bits written 0 unchanged.
REQ-006 A read SHALL be combinational: out_en=1 and dbus_out=register value while iore/ramre is high with an address match; otherwise out_en=0 and dbus_out=8'h00.
REQ-007 pinD_i SHALL pass through two synchronizer flops (s1, s2) into a history flop s3; an edge on bit n is s2[n]!=s3[n].
REQ-008 INT0 SHALL use bit 2 and INT1 bit 3. ISC encoding SHALL be: 00 low level, 01 any edge, 10 falling edge, 11 rising edge.
REQ-009 In edge modes, a qualifying edge SHALL set INTFx at the next cp2 edge; the pin change becomes visible in INTFx 3 edges after it is first sampled.
REQ-010 In low-level mode INTFx SHALL be held 0 and intx_irq SHALL equal EIMSK[x] & ~s2[bit].
REQ-011 In edge modes intx_irq SHALL equal EIMSK[x] & INTFx; pcint2_irq SHALL equal PCICR[2] & PCIFR[2]; all are combinational from registers.
REQ-012 PCIFR[2] SHALL set when |((s2^s3)&PCMSK2); flags SHALL set regardless of EIMSK/PCICR.
REQ-013 intx_ack / pcint2_ack high at an edge SHALL clear the matching flag.
REQ-014 A hardware set in the same cycle as a software clear or ack SHALL leave the flag at 1.
REQ-015 In the cycle EICRA is written, INTF set SHALL be suppressed so the mode change does not raise a spurious flag.
REQ-016 An arm counter (0..3) SHALL block all flag setting until it reaches 3, so that synchronizer fill after reset does not raise flags.

Reset
REQ-017 While ireset=1:
- s1, s2 and s3 SHALL be 8'hFF.
- The arm counter SHALL be 0.
- All registers SHALL be 0.
- All irq, INT0_EN, INT1_EN, PCIE2 and out_en outputs SHALL be 0; PCINT SHALL be 8'h00.
- dbus_out SHALL be 8'h00.
REQ-018 Assertion of ireset mid-operation SHALL abort any pending flag immediately.
REQ-019 After release, the arm counter SHALL increment once per edge and saturate at 3.

Verification
REQ-020 Reset with pinD_i=8'h00, hold 10 cycles -> EIFR=0, PCIFR=0, no irq.
REQ-021 EICRA=8'h02, EIMSK=8'h01, PD2 1->0 -> INTF0=1 on the 3rd edge, int0_irq=1; int0_ack -> INTF0=0 and irq drops next cycle.
REQ-022 EICRA=8'h00, EIMSK=8'h01, PD2 held low -> int0_irq=1 and EIFR reads 0; PD2 high -> irq=0 after 2 edges.
REQ-023 PCMSK2=8'h80, PCICR=8'h04, toggle PD6 then PD7 -> only the PD7 toggle sets PCIFR[2] and pcint2_irq=1; write PCIFR=8'h04 -> cleared.
REQ-024 Hardware edge and an iowe EIFR=8'h02 write in the same cycle -> INTF1 remains 1.
REQ-025 Flags set, then ireset pulsed asynchronously mid-cycle -> all flags and irqs 0 immediately, without waiting for a cp2 edge.
